i2c_master_burst: RTL and testbench

I2C_MASTER_BURST -- requirements
Module: i2c_master_burst

---
 rtl/i2c_pkg.sv | 63 ++++++
 rtl/i2c_qtr_tick.sv | 42 ++++
 rtl/i2c_master_burst.sv | 267 ++++++++++++++++++++++++++
 tb/tb_i2c_master_burst.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types and helpers for the I2C burst master:
//                FSM state encoding, SCL quarter phases, transfer direction
//                and the per-quarter bus drive table.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_ADDR_W = 4'd2,
        ST_ACK_A  = 4'd3,
        ST_REG    = 4'd4,
        ST_ACK_R  = 4'd5,
        ST_RSTART = 4'd6,
        ST_ADDR_R = 4'd7,
        ST_ACK_A2 = 4'd8,
        ST_WDATA  = 4'd9,
        ST_ACK_D  = 4'd10,
        ST_RDATA  = 4'd11,
        ST_MACK   = 4'd12,
        ST_STOP   = 4'd13
    } state_e;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } qtr_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Returns {scl_oe, sda_oe} for a given state and quarter. A set bit pulls
    // the line low; bit_val is the data bit being sent, mack_low requests an
    // acknowledge from the master in MACK.
    function automatic logic [1:0] line_drive(input state_e st, input qtr_e q,
                                              input logic bit_val, input logic mack_low);
        logic       scl_lo;
        logic       hi_half;
        logic [1:0] drv;
        scl_lo  = (q == Q0) || (q == Q1);
        hi_half = (q == Q2) || (q == Q3);
        drv     = 2'b00;
        case (st)
            ST_START:                                   drv = {1'b0, hi_half};
            ST_ADDR_W, ST_REG, ST_ADDR_R, ST_WDATA:     drv = {scl_lo, ~bit_val};
            ST_ACK_A, ST_ACK_R, ST_ACK_A2, ST_ACK_D,
            ST_RDATA:                                   drv = {scl_lo, 1'b0};
            ST_MACK:                                    drv = {scl_lo, mack_low};
            ST_RSTART:                                  drv = {q == Q0, hi_half};
            ST_STOP:                                    drv = {q == Q0, scl_lo};
            default:                                    drv = 2'b00;
        endcase
        return drv;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_qtr_tick.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_qtr_tick
//  Description : Quarter-period timebase. Emits a one-cycle tick every
//                QTR_DIV clocks; a synchronous clear holds the count at zero
//                so the first quarter of a transaction is full length.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_qtr_tick #(
    parameter int QTR_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] CNT_MAX = 8'(QTR_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Count up to CNT_MAX, tick on the terminal count and wrap.
    always_comb begin
        tick  = (cnt_q == CNT_MAX) && !clr;
        cnt_d = cnt_q + 8'd1;
        if (clr || tick) begin
            cnt_d = 8'd0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_master_burst.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_master_burst
//  Description : Single-master I2C register burst engine. Sends slave and
//                register address, then writes or (after a repeated START)
//                reads byte_count bytes. Open-drain drive via scl_oe/sda_oe.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_burst
    import i2c_pkg::*;
#(
    parameter int QTR_DIV = 4,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       slave_addr,
    input  logic [7:0]       reg_addr,
    input  logic [CNT_W-1:0] byte_count,
    input  logic [7:0]       tx_data,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             nack_err,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             sda_in
);

    state_e           state_q, state_d;
    qtr_e             qph_q, qph_d;
    logic [2:0]       bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rxsh_q, rxsh_d;
    logic             samp_q, samp_d;
    logic             rw_q, rw_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       reg_q, reg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tx_ready_q, tx_ready_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             nack_q, nack_d;
    logic             scl_oe_q, scl_oe_d;
    logic             sda_oe_q, sda_oe_d;
    logic             tick;

    i2c_qtr_tick #(
        .QTR_DIV (QTR_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (reset),
        .clr   (state_q == ST_IDLE),
        .tick  (tick)
    );

    // Next-state, datapath and bus-drive logic; lines are registered from the
    // next state so SCL/SDA change cleanly on quarter boundaries.
    always_comb begin
        state_d    = state_q;
        qph_d      = qph_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rxsh_d     = rxsh_q;
        samp_d     = samp_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        reg_d      = reg_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_ready_d = 1'b0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        nack_d     = nack_q;

        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_START;
                qph_d   = Q0;
                bit_d   = 3'd0;
                busy_d  = 1'b1;
                nack_d  = 1'b0;
                rw_d    = rw;
                addr_d  = slave_addr;
                reg_d   = reg_addr;
                cnt_d   = byte_count;
            end
        end else if (tick) begin
            qph_d = qtr_e'(qph_q + 2'd1);

            // Sample the bus on entry to q3 (SCL has been high for a quarter).
            if (qph_q == Q2) begin
                samp_d = sda_in;
                if (state_q == ST_RDATA) begin
                    rxsh_d = {rxsh_q[6:0], sda_in};
                    if (bit_q == 3'd0) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = {rxsh_q[6:0], sda_in};
                    end
                end
            end

            // End of a bit slot: move to the next bit or phase.
            if (qph_q == Q3) begin
                case (state_q)
                    ST_START: begin
                        state_d = ST_ADDR_W;
                        shift_d = {addr_q, RW_WRITE};
                        bit_d   = 3'd7;
                    end
                    ST_ADDR_W, ST_REG, ST_ADDR_R, ST_WDATA: begin
                        if (bit_q == 3'd0) begin
                            case (state_q)
                                ST_ADDR_W: state_d = ST_ACK_A;
                                ST_REG:    state_d = ST_ACK_R;
                                ST_ADDR_R: state_d = ST_ACK_A2;
                                default:   state_d = ST_ACK_D;
                            endcase
                        end else begin
                            bit_d   = bit_q - 3'd1;
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                    ST_ACK_A: begin
                        if (samp_q) begin
                            nack_d  = 1'b1;
                            state_d = ST_STOP;
                        end else begin
                            state_d = ST_REG;
                            shift_d = reg_q;
                            bit_d   = 3'd7;
                        end
                    end
                    ST_ACK_R: begin
                        if (samp_q) begin
                            nack_d  = 1'b1;
                            state_d = ST_STOP;
                        end else if (cnt_q == '0) begin
                            state_d = ST_STOP;
                        end else if (rw_q == RW_READ) begin
                            state_d = ST_RSTART;
                        end else begin
                            state_d    = ST_WDATA;
                            shift_d    = tx_data;
                            tx_ready_d = 1'b1;
                            bit_d      = 3'd7;
                        end
                    end
                    ST_RSTART: begin
                        state_d = ST_ADDR_R;
                        shift_d = {addr_q, RW_READ};
                        bit_d   = 3'd7;
                    end
                    ST_ACK_A2: begin
                        if (samp_q) begin
                            nack_d  = 1'b1;
                            state_d = ST_STOP;
                        end else begin
                            state_d = ST_RDATA;
                            bit_d   = 3'd7;
                        end
                    end
                    ST_ACK_D: begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (samp_q) begin
                            nack_d  = 1'b1;
                            state_d = ST_STOP;
                        end else if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_STOP;
                        end else begin
                            state_d    = ST_WDATA;
                            shift_d    = tx_data;
                            tx_ready_d = 1'b1;
                            bit_d      = 3'd7;
                        end
                    end
                    ST_RDATA: begin
                        if (bit_q == 3'd0) begin
                            state_d = ST_MACK;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                    ST_MACK: begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_STOP;
                        end else begin
                            state_d = ST_RDATA;
                            bit_d   = 3'd7;
                        end
                    end
                    ST_STOP: begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        // The last read byte is NACKed by the master so the slave lets go.
        {scl_oe_d, sda_oe_d} = line_drive(state_d, qph_d, shift_d[7], cnt_d != CNT_W'(1));
    end

    // State and datapath registers; reset releases both lines immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            qph_q      <= Q0;
            bit_q      <= 3'd0;
            cnt_q      <= '0;
            shift_q    <= 8'd0;
            rxsh_q     <= 8'd0;
            samp_q     <= 1'b0;
            rw_q       <= RW_WRITE;
            addr_q     <= 7'd0;
            reg_q      <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
            nack_q     <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            qph_q      <= qph_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rxsh_q     <= rxsh_d;
            samp_q     <= samp_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            reg_q      <= reg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            nack_q     <= nack_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign nack_err = nack_q;
    assign scl_oe   = scl_oe_q;
    assign sda_oe   = sda_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_master_burst
//  Description : Self-checking bench for i2c_master_burst with a bit-level
//                I2C slave model and byte scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_master_burst;
    import i2c_pkg::*;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rw;
    logic [6:0] slave_addr;
    logic [7:0] reg_addr;
    logic [3:0] byte_count;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       nack_err;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_in;

    // Open-drain bus as seen by everyone
    logic sda_slave = 1'b1;
    logic scl_b, sda_b;
    assign scl_b  = ~scl_oe;
    assign sda_b  = ~sda_oe & sda_slave;
    assign sda_in = sda_b;

    // Stimulus tables and bench state
    logic [7:0] tx_tbl [0:255];
    logic [7:0] rd_tbl [0:255];
    logic [7:0] tx_cnt = 8'd0;
    int         nack_byte = -1;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_q [$];

    // Monitor / slave state
    logic [7:0] obs_bytes [$];
    logic       obs_mack [$];
    logic [7:0] rx_obs [$];
    int         n_start = 0, n_stop = 0, n_rise = 0;
    int         m_bitpos = 0, m_byte_idx = 0, m_rd_idx = 0;
    logic       m_read = 1'b0, m_rd_done = 1'b0;
    logic [7:0] m_shift = 8'd0, m_cur = 8'd0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;

    assign tx_data = tx_tbl[tx_cnt];

    i2c_master_burst #(
        .QTR_DIV (Q),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rw         (rw),
        .slave_addr (slave_addr),
        .reg_addr   (reg_addr),
        .byte_count (byte_count),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .done       (done),
        .nack_err   (nack_err),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .sda_in     (sda_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Bus monitor and slave model, evaluated mid-cycle
    always @(negedge clk) begin
        if (tx_ready) tx_cnt = tx_cnt + 8'd1;
        if (rx_valid) rx_obs.push_back(rx_data);
        if (prev_scl && scl_b && prev_sda && !sda_b) begin
            n_start++;
            m_bitpos = 0; m_byte_idx = 0; m_read = 1'b0; m_rd_done = 1'b0;
            sda_slave = 1'b1;
        end else if (prev_scl && scl_b && !prev_sda && sda_b) begin
            n_stop++;
        end else if (!prev_scl && scl_b) begin
            n_rise++;
            if (m_bitpos < 8) begin
                m_shift = {m_shift[6:0], sda_b};
            end else if (m_read && m_byte_idx > 0) begin
                obs_mack.push_back(sda_b);
                if (sda_b) m_rd_done = 1'b1;
            end
            m_bitpos++;
            if (m_bitpos == 9) begin
                if (!(m_read && m_byte_idx > 0)) obs_bytes.push_back(m_shift);
                if (m_byte_idx == 0) m_read = m_shift[0];
                m_byte_idx++;
                m_bitpos = 0;
            end
        end else if (prev_scl && !scl_b) begin
            sda_slave = 1'b1;
            if (m_bitpos == 8 && !(m_read && m_byte_idx > 0)) begin
                sda_slave = (m_byte_idx == nack_byte) ? 1'b1 : 1'b0;
            end else if (m_bitpos < 8 && m_read && m_byte_idx > 0 && !m_rd_done) begin
                if (m_bitpos == 0) begin
                    m_cur = rd_tbl[m_rd_idx];
                    m_rd_idx++;
                end
                sda_slave = m_cur[7 - m_bitpos];
            end
        end
        prev_scl = scl_b;
        prev_sda = ~sda_oe & sda_slave;
    end

    task automatic pulse_start(input logic r, input logic [6:0] a, input logic [7:0] rg,
                               input logic [3:0] n, output int c0);
        @(negedge clk);
        rw = r; slave_addr = a; reg_addr = rg; byte_count = n; start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int lat);
        lat = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - c0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; rw = 1'b0; slave_addr = 7'd0; reg_addr = 8'd0; byte_count = 4'd0;
        repeat (3) @(negedge clk);
        n_total++; if (scl_oe !== 1'b0) $display("FAIL rst_scl_oe: got %b need 0", scl_oe); else n_pass++;
        n_total++; if (sda_oe !== 1'b0) $display("FAIL rst_sda_oe: got %b need 0", sda_oe); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b need 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b need 0", done); else n_pass++;
        n_total++; if (tx_ready !== 1'b0) $display("FAIL rst_tx_ready: got %b need 0", tx_ready); else n_pass++;
        n_total++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b need 0", rx_valid); else n_pass++;
        n_total++; if (nack_err !== 1'b0) $display("FAIL rst_nack_err: got %b need 0", nack_err); else n_pass++;
        n_total++; if (rx_data !== 8'h00) $display("FAIL rst_rx_data: got %h need 00", rx_data); else n_pass++;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b need 0", busy); else n_pass++;
    endtask

    task automatic test_write();
        int c0, lat, b0, t0, s0, p0;
        logic [7:0] e;
        b0 = obs_bytes.size(); t0 = int'(tx_cnt); s0 = n_start; p0 = n_stop;
        tx_tbl[tx_cnt] = 8'hA5; tx_tbl[tx_cnt + 8'd1] = 8'h3C;
        exp_q.push_back(8'hA0); exp_q.push_back(8'h10); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        pulse_start(RW_WRITE, 7'h50, 8'h10, 4'd2, c0);
        n_total++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b need 1", busy); else n_pass++;
        wait_done(c0, lat);
        n_total++;
        if (lat < 152*Q-2 || lat > 152*Q+2) $display("FAIL wr_latency: got %0d need %0d", lat, 152*Q); else n_pass++;
        n_total++;
        if (obs_bytes.size()-b0 != exp_q.size()) $display("FAIL wr_nbytes: got %0d need %0d", obs_bytes.size()-b0, exp_q.size()); else n_pass++;
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            n_total++;
            if (b0+k >= obs_bytes.size()) $display("FAIL wr_byte%0d: got none need %h", k, e);
            else if (obs_bytes[b0+k] !== e) $display("FAIL wr_byte%0d: got %h need %h", k, obs_bytes[b0+k], e);
            else n_pass++;
        end
        n_total++; if (int'(tx_cnt)-t0 != 2) $display("FAIL wr_tx_ready: got %0d need 2", int'(tx_cnt)-t0); else n_pass++;
        n_total++; if (nack_err !== 1'b0) $display("FAIL wr_nack_err: got %b need 0", nack_err); else n_pass++;
        n_total++; if (n_start-s0 != 1 || n_stop-p0 != 1) $display("FAIL wr_start_stop: got %0d/%0d need 1/1", n_start-s0, n_stop-p0); else n_pass++;
    endtask

    task automatic test_read();
        int c0, lat, b0, r0, a0, s0;
        logic [7:0] e;
        b0 = obs_bytes.size(); r0 = rx_obs.size(); a0 = obs_mack.size(); s0 = n_start;
        rd_tbl[m_rd_idx] = 8'h5A; rd_tbl[m_rd_idx+1] = 8'hC3;
        exp_q.push_back(8'hA0); exp_q.push_back(8'h10); exp_q.push_back(8'hA1);
        pulse_start(RW_READ, 7'h50, 8'h10, 4'd2, c0);
        wait_done(c0, lat);
        n_total++;
        if (lat < 192*Q-2 || lat > 192*Q+2) $display("FAIL rd_latency: got %0d need %0d", lat, 192*Q); else n_pass++;
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            n_total++;
            if (b0+k >= obs_bytes.size()) $display("FAIL rd_byte%0d: got none need %h", k, e);
            else if (obs_bytes[b0+k] !== e) $display("FAIL rd_byte%0d: got %h need %h", k, obs_bytes[b0+k], e);
            else n_pass++;
        end
        exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
        n_total++; if (rx_obs.size()-r0 != 2) $display("FAIL rd_nrx: got %0d need 2", rx_obs.size()-r0); else n_pass++;
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            n_total++;
            if (r0+k >= rx_obs.size()) $display("FAIL rd_rx%0d: got none need %h", k, e);
            else if (rx_obs[r0+k] !== e) $display("FAIL rd_rx%0d: got %h need %h", k, rx_obs[r0+k], e);
            else n_pass++;
        end
        n_total++;
        if (obs_mack.size()-a0 != 2) $display("FAIL rd_mack_n: got %0d need 2", obs_mack.size()-a0);
        else if (obs_mack[a0] !== 1'b0 || obs_mack[a0+1] !== 1'b1) $display("FAIL rd_mack: got %b%b need 01", obs_mack[a0], obs_mack[a0+1]);
        else n_pass++;
        n_total++; if (n_start-s0 != 2) $display("FAIL rd_rstart: got %0d starts need 2", n_start-s0); else n_pass++;
    endtask

    task automatic test_addr_nack();
        int c0, lat, b0, t0, p0;
        b0 = obs_bytes.size(); t0 = int'(tx_cnt); p0 = n_stop;
        nack_byte = 0;
        pulse_start(RW_WRITE, 7'h50, 8'h10, 4'd2, c0);
        wait_done(c0, lat);
        nack_byte = -1;
        n_total++; if (lat < 44*Q-2 || lat > 44*Q+2) $display("FAIL nack_latency: got %0d need %0d", lat, 44*Q); else n_pass++;
        n_total++; if (nack_err !== 1'b1) $display("FAIL nack_err: got %b need 1", nack_err); else n_pass++;
        n_total++; if (int'(tx_cnt) != t0) $display("FAIL nack_tx_ready: got %0d need 0", int'(tx_cnt)-t0); else n_pass++;
        n_total++; if (obs_bytes.size()-b0 != 1) $display("FAIL nack_nbytes: got %0d need 1", obs_bytes.size()-b0); else n_pass++;
        n_total++; if (n_stop-p0 != 1) $display("FAIL nack_stop: got %0d need 1", n_stop-p0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int c0, lat, r0, b0;
        logic [7:0] e;
        logic hit;
        tx_tbl[tx_cnt] = 8'h96;
        r0 = n_rise; hit = 1'b0;
        pulse_start(RW_WRITE, 7'h50, 8'h10, 4'd2, c0);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (n_rise - r0 >= 22) begin hit = 1'b1; break; end
        end
        n_total++; if (!hit) $display("FAIL mid_reach_bit4: got timeout need 22 clocks"); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) $display("FAIL mid_lines: got %b%b need 00", scl_oe, sda_oe); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b need 0", busy); else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        b0 = obs_bytes.size();
        tx_tbl[tx_cnt] = 8'h77;
        exp_q.push_back(8'hA0); exp_q.push_back(8'h10); exp_q.push_back(8'h77);
        pulse_start(RW_WRITE, 7'h50, 8'h10, 4'd1, c0);
        wait_done(c0, lat);
        n_total++; if (lat < 116*Q-2 || lat > 116*Q+2) $display("FAIL mid_latency: got %0d need %0d", lat, 116*Q); else n_pass++;
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            n_total++;
            if (b0+k >= obs_bytes.size()) $display("FAIL mid_byte%0d: got none need %h", k, e);
            else if (obs_bytes[b0+k] !== e) $display("FAIL mid_byte%0d: got %h need %h", k, obs_bytes[b0+k], e);
            else n_pass++;
        end
    endtask

    task automatic test_busy_zero();
        int c0, lat, b0, t0, x0;
        logic [7:0] e;
        b0 = obs_bytes.size(); t0 = int'(tx_cnt); x0 = rx_obs.size();
        exp_q.push_back(8'hA0); exp_q.push_back(8'h10);
        pulse_start(RW_READ, 7'h50, 8'h10, 4'd0, c0);
        repeat (10) @(negedge clk);
        rw = RW_WRITE; slave_addr = 7'h22; reg_addr = 8'hEE; byte_count = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c0, lat);
        n_total++; if (lat < 80*Q-2 || lat > 80*Q+2) $display("FAIL zero_latency: got %0d need %0d", lat, 80*Q); else n_pass++;
        repeat (60) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL ignored_busy: got %b need 0", busy); else n_pass++;
        n_total++;
        if (obs_bytes.size()-b0 != exp_q.size()) $display("FAIL zero_nbytes: got %0d need %0d", obs_bytes.size()-b0, exp_q.size()); else n_pass++;
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            n_total++;
            if (b0+k >= obs_bytes.size()) $display("FAIL zero_byte%0d: got none need %h", k, e);
            else if (obs_bytes[b0+k] !== e) $display("FAIL zero_byte%0d: got %h need %h", k, obs_bytes[b0+k], e);
            else n_pass++;
        end
        n_total++;
        if (int'(tx_cnt) != t0 || rx_obs.size() != x0) $display("FAIL zero_data: got tx %0d rx %0d need 0 0", int'(tx_cnt)-t0, rx_obs.size()-x0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_reset_mid();
        test_busy_zero();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
